// File: rtl/transfer_center_pkg.sv
// -----------------------------------------------------------------------------
// transfer_center_pkg
// Shared constants for the transfer-center serial link: command codes, the idle
// byte and the slot width. Used by both the transmitter and the receiver.
// Also holds the transmitter's two-state FSM type and a code-legality helper.
// -----------------------------------------------------------------------------
package transfer_center_pkg;

    localparam int unsigned SLOT_W = 8;

    localparam logic [SLOT_W-1:0] CMD_IDLE   = 8'h00;
    localparam logic [SLOT_W-1:0] CMD_50     = 8'h01;
    localparam logic [SLOT_W-1:0] CMD_80     = 8'h02;
    localparam logic [SLOT_W-1:0] CMD_90     = 8'h03;
    localparam logic [SLOT_W-1:0] CMD_100    = 8'h04;
    localparam logic [SLOT_W-1:0] CMD_FLUSH  = 8'h05;
    localparam logic [SLOT_W-1:0] CMD_READY  = 8'h06;
    localparam logic [SLOT_W-1:0] CMD_BINARY = 8'h07;
    localparam logic [SLOT_W-1:0] CMD_ASCII  = 8'h08;

    // DATA_NEXT means the following slot must carry the held binary data byte.
    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_DATA_NEXT = 1'b1
    } tx_state_e;

    function automatic logic cmd_is_legal(input logic [SLOT_W-1:0] code);
        return (code >= CMD_50) && (code <= CMD_ASCII);
    endfunction

endpackage

// File: rtl/transfer_center_tx_if.sv
// -----------------------------------------------------------------------------
// transfer_center_tx_if
// Command handshake between the local controller (master) and the serial
// transmitter (slave).
//   cmdValid : command offered
//   cmdCode  : command byte
//   cmdData  : data byte, used only with the binary command
//   cmdReady : command taken on this edge when cmdValid is high
// -----------------------------------------------------------------------------
interface transfer_center_tx_if;
    import transfer_center_pkg::*;

    logic              cmdValid;
    logic [SLOT_W-1:0] cmdCode;
    logic [SLOT_W-1:0] cmdData;
    logic              cmdReady;

    modport master (output cmdValid, output cmdCode, output cmdData, input  cmdReady);
    modport slave  (input  cmdValid, input  cmdCode, input  cmdData, output cmdReady);

endinterface

// File: rtl/transfer_center_tx_shifter.sv
// -----------------------------------------------------------------------------
// transfer_center_tx_shifter
// Free-running 8-clock slot counter and MSB-first output shift register.
// On a boundary edge (slot counter at 7) the slot byte is loaded, otherwise the
// register shifts left filling zeros.
//   clk, rst     : clock, asynchronous active-low reset
//   loadByte_i   : byte to load at the next boundary edge
//   boundary_o   : the coming edge is a boundary edge
//   dataOut_o    : serial bit (shift register MSB)
//   slotStart_o  : registered, high while dataOut_o carries bit 7
// -----------------------------------------------------------------------------
module transfer_center_tx_shifter
    import transfer_center_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] loadByte_i,
    output logic              boundary_o,
    output logic              dataOut_o,
    output logic              slotStart_o
);

    logic [2:0]        slotCnt_q;
    logic [SLOT_W-1:0] shiftReg_q;
    logic              slotStart_q;

    assign boundary_o  = (slotCnt_q == 3'd7);
    assign dataOut_o   = shiftReg_q[SLOT_W-1];
    assign slotStart_o = slotStart_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slotCnt_q   <= 3'd7;
            shiftReg_q  <= '0;
            slotStart_q <= 1'b0;
        end else begin
            slotCnt_q   <= slotCnt_q + 3'd1;
            slotStart_q <= boundary_o;
            if (boundary_o) begin
                shiftReg_q <= loadByte_i;
            end else begin
                shiftReg_q <= {shiftReg_q[SLOT_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/transfer_center_tx.sv
// -----------------------------------------------------------------------------
// transfer_center_tx
// Serial command transmitter for the transfer-center link. One command byte
// per 8-clock slot, MSB first; the binary command (7) is followed by its data
// byte in the very next slot. Slots run freely from reset so the receiver stays
// byte-aligned without a framing wire.
//   clk                : clock
//   rst                : asynchronous active-low reset
//   readyForTransferIn : downstream link ready; low blocks new commands
//   cmd                : command handshake (slave modport)
//   dataOut            : serial bit, MSB first
//   slotStart          : high during bit 7 of every slot
//   busy               : current or next slot carries a non-idle byte
//   errPulse           : one-cycle pulse after an illegal code was dropped
// Build option: TC_TX_IDLE_READY_EN -- idle slots carry 0x06 when the link is
// ready at the boundary, otherwise idle slots are always 0x00.
// -----------------------------------------------------------------------------
module transfer_center_tx
    import transfer_center_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 readyForTransferIn,
    transfer_center_tx_if.slave  cmd,
    output logic                 dataOut,
    output logic                 slotStart,
    output logic                 busy,
    output logic                 errPulse
);

    logic              boundary;
    logic              accept;
    logic              legal;
    logic [SLOT_W-1:0] idleByte;
    logic [SLOT_W-1:0] loadByte_d;

    tx_state_e         state_q;
    logic [SLOT_W-1:0] dataHold_q;
    logic              slotBusy_q;
    logic              errPulse_q;

    // A pending data byte owns the next slot regardless of link-ready, so the
    // receiver never sees a binary command without its data.
    assign cmd.cmdReady = boundary && (state_q == ST_NORMAL) && readyForTransferIn;
    assign accept       = cmd.cmdValid && cmd.cmdReady;
    assign legal        = cmd_is_legal(cmd.cmdCode);

`ifdef TC_TX_IDLE_READY_EN
    assign idleByte = readyForTransferIn ? CMD_READY : CMD_IDLE;
`else
    assign idleByte = CMD_IDLE;
`endif

    always_comb begin
        loadByte_d = idleByte;
        if (state_q == ST_DATA_NEXT) begin
            loadByte_d = dataHold_q;
        end else if (accept && legal) begin
            loadByte_d = cmd.cmdCode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            dataHold_q <= '0;
            slotBusy_q <= 1'b0;
            errPulse_q <= 1'b0;
        end else begin
            errPulse_q <= accept && !legal;
            if (boundary) begin
                slotBusy_q <= (state_q == ST_DATA_NEXT) || (accept && legal);
                case (state_q)
                    ST_DATA_NEXT: state_q <= ST_NORMAL;
                    default: begin
                        if (accept && legal && (cmd.cmdCode == CMD_BINARY)) begin
                            dataHold_q <= cmd.cmdData;
                            state_q    <= ST_DATA_NEXT;
                        end
                    end
                endcase
            end
        end
    end

    assign busy     = slotBusy_q || (state_q == ST_DATA_NEXT);
    assign errPulse = errPulse_q;

    transfer_center_tx_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .loadByte_i  (loadByte_d),
        .boundary_o  (boundary),
        .dataOut_o   (dataOut),
        .slotStart_o (slotStart)
    );

endmodule

// File: tb/tb_transfer_center_tx.sv
// -----------------------------------------------------------------------------
// tb_transfer_center_tx
// Directed scenarios plus randomized traffic for transfer_center_tx. A byte-level
// model of the link (slot index since reset, current slot byte, pending data
// byte) predicts every output each cycle; directed scenarios also pin literal
// bit patterns. Honours TC_TX_IDLE_READY_EN for the expected idle byte.
// -----------------------------------------------------------------------------
module tb_transfer_center_tx;
    import transfer_center_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b1;
    logic dataOut, slotStart, busy, errPulse;

    transfer_center_tx_if cif ();

    transfer_center_tx dut (
        .clk                (clk),
        .rst                (rst),
        .readyForTransferIn (ready),
        .cmd                (cif),
        .dataOut            (dataOut),
        .slotStart          (slotStart),
        .busy               (busy),
        .errPulse           (errPulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Link model: edges since reset, byte in the current slot, held data byte.
    int unsigned m_e;
    logic [7:0]  m_cur;
    logic [7:0]  m_hold;
    logic        m_pend;
    logic        m_curBusy;
    logic        m_err;
    logic        m_acc;

    logic last_dout, last_slot, last_busy, last_err, last_crdy;

    function automatic logic [7:0] idle_byte(input logic rdy);
`ifdef TC_TX_IDLE_READY_EN
        return rdy ? 8'h06 : 8'h00;
`else
        return (rdy && 1'b0) ? 8'h06 : 8'h00;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_cur = 8'h00; m_hold = 8'h00;
        m_pend = 1'b0; m_curBusy = 1'b0; m_err = 1'b0; m_acc = 1'b0;
    endtask

    task automatic model_edge(input logic rdy_pred);
        if (m_e % 8 == 0) begin
            m_err = 1'b0;
            if (m_pend) begin
                m_cur = m_hold; m_pend = 1'b0; m_curBusy = 1'b1;
            end else if (cif.cmdValid && rdy_pred) begin
                m_acc = 1'b1;
                if (cif.cmdCode >= 8'd1 && cif.cmdCode <= 8'd8) begin
                    m_cur = cif.cmdCode; m_curBusy = 1'b1;
                    if (cif.cmdCode == 8'd7) begin
                        m_hold = cif.cmdData; m_pend = 1'b1;
                    end
                end else begin
                    m_cur = idle_byte(ready); m_curBusy = 1'b0; m_err = 1'b1;
                end
            end else begin
                m_cur = idle_byte(ready); m_curBusy = 1'b0;
            end
        end else begin
            m_err = 1'b0;
        end
        m_e++;
    endtask

    // One clock: check cmdReady before the edge, advance model, check outputs after.
    task automatic step();
        logic exp_rdy;
        logic e_dout, e_slot, e_busy, e_err;
        int unsigned pos;
        @(negedge clk);
        exp_rdy = (m_e % 8 == 0) && !m_pend && ready;
        last_crdy = cif.cmdReady;
        chk("cmdReady", {31'd0, cif.cmdReady}, {31'd0, exp_rdy});
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) model_edge(exp_rdy);
        #1;
        if (m_e == 0) begin
            e_dout = 1'b0; e_slot = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            pos    = (m_e - 1) % 8;
            e_dout = m_cur[7 - pos];
            e_slot = (pos == 0);
            e_busy = m_curBusy || m_pend;
            e_err  = m_err;
        end
        chk("dataOut",   {31'd0, dataOut},   {31'd0, e_dout});
        chk("slotStart", {31'd0, slotStart}, {31'd0, e_slot});
        chk("busy",      {31'd0, busy},      {31'd0, e_busy});
        chk("errPulse",  {31'd0, errPulse},  {31'd0, e_err});
        last_dout = dataOut; last_slot = slotStart; last_busy = busy; last_err = errPulse;
    endtask

    task automatic to_boundary();
        for (int i = 0; i < 8 && (m_e % 8 != 0); i++) step();
    endtask

    task automatic run_bits(input int n, input logic drop,
                            output logic [15:0] bits, output int nbusy, output int nerr,
                            output logic crdy_mid, output logic first_slot);
        bits = '0; nbusy = 0; nerr = 0; crdy_mid = 1'b1; first_slot = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (drop && i == 0) cif.cmdValid = 1'b0;
            if (i == 0) first_slot = last_slot;
            if (i == 8) crdy_mid = last_crdy;
            bits  = {bits[14:0], last_dout};
            nbusy += int'(last_busy);
            nerr  += int'(last_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits;
        int          nb, ne;
        logic        cm, fs;
        logic [7:0]  b;
        logic        or_rdy, or_dout;
        logic [15:0] idle2;

        model_reset();
        cif.cmdValid = 1'b0; cif.cmdCode = 8'h00; cif.cmdData = 8'h00;

        // Reset values
        step(); step();
        chk("rst_dataOut",   {31'd0, dataOut},      32'd0);
        chk("rst_slotStart", {31'd0, slotStart},    32'd0);
        chk("rst_busy",      {31'd0, busy},         32'd0);
        chk("rst_errPulse",  {31'd0, errPulse},     32'd0);
        chk("rst_cmdReady",  {31'd0, cif.cmdReady}, 32'd1);

        // Command 0x03 on the first edge after release
        rst = 1'b1; cif.cmdValid = 1'b1; cif.cmdCode = 8'h03;
        run_bits(8, 1'b1, bits, nb, ne, cm, fs);
        chk("t1_bits",      {24'd0, bits[7:0]}, 32'h03);
        chk("t1_slotStart", {31'd0, fs},        32'd1);
        chk("t1_busy",      nb,                 32'd8);

        // Binary command with data 0xA5
        to_boundary();
        cif.cmdValid = 1'b1; cif.cmdCode = 8'h07; cif.cmdData = 8'hA5;
        run_bits(16, 1'b1, bits, nb, ne, cm, fs);
        chk("t2_bits",      bits,         32'h07A5);
        chk("t2_busy",      nb,           32'd16);
        chk("t2_midReady",  {31'd0, cm},  32'd0);

        // Illegal code 0x0C, then legal 0x01 at the following boundary
        to_boundary();
        cif.cmdValid = 1'b1; cif.cmdCode = 8'h0C;
        step();
        chk("t3_errPulse", {31'd0, last_err}, 32'd1);
        b = {7'd0, last_dout};
        cif.cmdCode = 8'h01;
        ne = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            b  = {b[6:0], last_dout};
            ne += int'(last_err);
        end
        chk("t3_idle",      {24'd0, b}, {24'd0, idle_byte(1'b1)});
        chk("t3_errOnce",   ne,         32'd0);
        run_bits(8, 1'b1, bits, nb, ne, cm, fs);
        chk("t3_next",      {24'd0, bits[7:0]}, 32'h01);

        // Link not ready for 3 slots with a held command
        to_boundary();
        ready = 1'b0; cif.cmdValid = 1'b1; cif.cmdCode = 8'h04;
        or_rdy = 1'b0; or_dout = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            or_rdy  |= last_crdy;
            or_dout |= last_dout;
        end
        chk("t4_noAccept", {31'd0, or_rdy},  32'd0);
        chk("t4_idle",     {31'd0, or_dout}, 32'd0);
        ready = 1'b1;
        run_bits(8, 1'b1, bits, nb, ne, cm, fs);
        chk("t4_sent",     {24'd0, bits[7:0]}, 32'h04);

        // Reset in the middle of a binary data byte
        to_boundary();
        cif.cmdValid = 1'b1; cif.cmdCode = 8'h07; cif.cmdData = 8'h3C;
        run_bits(11, 1'b1, bits, nb, ne, cm, fs);
        #2; rst = 1'b0; #1;
        chk("t5_dataOut",   {31'd0, dataOut},   32'd0);
        chk("t5_busy",      {31'd0, busy},      32'd0);
        chk("t5_slotStart", {31'd0, slotStart}, 32'd0);
        model_reset();
        step(); step();
        rst = 1'b1;
        run_bits(8, 1'b0, bits, nb, ne, cm, fs);
        chk("t5_noData",   {24'd0, bits[7:0]}, {24'd0, idle_byte(1'b1)});
        chk("t5_notBusy",  nb,                 32'd0);

        // Idle stream
        to_boundary();
        run_bits(16, 1'b0, bits, nb, ne, cm, fs);
`ifdef TC_TX_IDLE_READY_EN
        idle2 = 16'h0606;
`else
        idle2 = 16'h0000;
`endif
        chk("t6_idle", bits, {16'd0, idle2});

        // Randomized traffic; command held until the model sees it accepted
        for (int i = 0; i < 600; i++) begin
            if (!cif.cmdValid || m_acc) begin
                cif.cmdValid = ($urandom_range(0, 3) != 0);
                cif.cmdCode  = ($urandom_range(0, 7) != 0) ? 8'($urandom_range(1, 8))
                                                           : 8'($urandom_range(0, 255));
                cif.cmdData  = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 9) == 0) ready = ~ready;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
